// File: rtl/next_pc_unit.sv
// -----------------------------------------------------------------------------
// next_pc_unit
//   Selects and registers the next fetch PC. The priority, highest first, is
//   exception > stall > return > jump/call > branch > sequential (pc + 4).
//   An optional return-address stack (RAS) supplies targets for returns.
//
// Build option:
//   NEXT_PC_RAS_EN  - when defined, the return-address stack is included.
//                     When undefined, call is ignored, ret is treated as no
//                     request, ras_empty is tied to 1, and ras_full and
//                     ras_underflow are tied to 0.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-high reset (pc <- RESET_VECTOR)
//   stall          hold pc, RAS and pulses (exc_req still wins)
//   exc_req        redirect to EXC_VECTOR and flush the RAS
//   jump_en        absolute redirect to jump_target
//   jump_target    absolute target
//   call           with jump_en, also push pc + 4 onto the RAS
//   ret            redirect to the popped return address
//   branch_en      relative redirect to pc + branch_offset
//   branch_offset  two's-complement byte offset
//   pc             current PC (registered)
//   pc_plus4       pc + 4 (combinational)
//   ras_empty      RAS holds no entries
//   ras_full       RAS holds RAS_DEPTH entries
//   misalign       one-cycle pulse: a taken target had nonzero bits [1:0]
//   ras_underflow  one-cycle pulse: ret taken while the RAS was empty
// -----------------------------------------------------------------------------
module next_pc_unit #(
  parameter int unsigned ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h00003000,
  parameter logic [31:0] EXC_VECTOR   = 32'h00004180,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              exc_req,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              call,
  input  logic              ret,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              misalign,
  output logic              ras_underflow
);

  localparam logic [ADDR_W-1:0] RST_PC     = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] EXC_PC     = ADDR_W'(EXC_VECTOR);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  // Signals shared between the PC selector and the (optional) RAS.
  logic              ret_ok;        // ret is a live request in this build
  logic              call_ok;       // call is a live qualifier in this build
  logic              ras_is_empty;  // current RAS count is zero
  logic [ADDR_W-1:0] ras_top;       // entry a pop would return

  logic              push;
  logic              pop;
  logic              flush;

  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] target;
  logic              targeted;
  logic              misalign_nxt;
  logic              underflow_nxt;

  assign pc_plus4 = pc + PC_STEP;

  // Next-PC selection in priority order; redirect targets are word-aligned.
  always_comb begin
    pc_nxt        = pc;
    target        = '0;
    targeted      = 1'b0;
    misalign_nxt  = 1'b0;
    underflow_nxt = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    flush         = 1'b0;

    if (exc_req) begin
      pc_nxt = EXC_PC;
      flush  = 1'b1;
    end else if (stall) begin
      pc_nxt = pc;
    end else if (ret_ok) begin
      targeted = 1'b1;
      if (ras_is_empty) begin
        target        = pc_plus4;
        underflow_nxt = 1'b1;
      end else begin
        target = ras_top;
        pop    = 1'b1;
      end
    end else if (jump_en) begin
      targeted = 1'b1;
      target   = jump_target;
      push     = call_ok;
    end else if (branch_en) begin
      targeted = 1'b1;
      target   = pc + branch_offset;
    end else begin
      pc_nxt = pc_plus4;
    end

    if (targeted) begin
      pc_nxt       = target & ALIGN_MASK;
      misalign_nxt = |target[1:0];
    end
  end

  // PC and misalign pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= RST_PC;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_nxt;
      misalign <= misalign_nxt;
    end
  end

`ifdef NEXT_PC_RAS_EN

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  // Circular stack: top_q points at the newest entry. A push on a full stack
  // lands on the oldest slot, which is exactly top_q + 1 when count is full.
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top_q;
  logic [PTR_W-1:0]  top_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_nxt;

  assign ret_ok       = ret;
  assign call_ok      = call;
  assign ras_is_empty = (cnt_q == '0);
  assign ras_top      = ras_mem[top_q];

  // Stack pointer and saturating count update.
  always_comb begin
    cnt_nxt = cnt_q;
    top_nxt = top_q;
    if (flush) begin
      cnt_nxt = '0;
    end else if (pop) begin
      cnt_nxt = cnt_q - CNT_W'(1);
      top_nxt = top_q - PTR_W'(1);
    end else if (push) begin
      top_nxt = top_q + PTR_W'(1);
      if (cnt_q != CNT_MAX) begin
        cnt_nxt = cnt_q + CNT_W'(1);
      end
    end
  end

  // Stack control and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      top_q         <= '0;
      cnt_q         <= '0;
      ras_empty     <= 1'b1;
      ras_full      <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      top_q         <= top_nxt;
      cnt_q         <= cnt_nxt;
      ras_empty     <= (cnt_nxt == '0);
      ras_full      <= (cnt_nxt == CNT_MAX);
      ras_underflow <= underflow_nxt;
    end
  end

  // Entry storage; contents survive reset, only the count is cleared.
  always_ff @(posedge clock) begin
    if (push) begin
      ras_mem[top_q + PTR_W'(1)] <= pc_plus4;
    end
  end

`else

  logic unused_ras;

  assign ret_ok        = 1'b0;
  assign call_ok       = 1'b0;
  assign ras_is_empty  = 1'b1;
  assign ras_top       = '0;
  assign ras_empty     = 1'b1;
  assign ras_full      = 1'b0;
  assign ras_underflow = 1'b0;
  assign unused_ras    = ^{call, ret, push, pop, flush, underflow_nxt};

`endif

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL have parameter ADDR_W, 32, PC width in bits (>= 8).
REQ-002 SHALL have parameter RESET_VECTOR, 32'h00003000, PC value loaded on reset.
REQ-003 SHALL have parameter EXC_VECTOR, 32'h00004180, PC value loaded on exception.
REQ-004 SHALL have parameter RAS_DEPTH, 4, return-address-stack entries (power of two, >= 2).
REQ-005 SHALL have port clock  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port stall  input  1  hold PC.
REQ-008 SHALL have port exc_req  input  1  redirect to EXC_VECTOR.
REQ-009 SHALL have port jump_en  input  1  absolute redirect.
REQ-010 SHALL have port jump_target  input  ADDR_W  absolute target.
REQ-011 SHALL have port call  input  1  qualifies jump_en as a call (push return address).
REQ-012 SHALL have port ret  input  1  redirect to the popped return address.
REQ-013 SHALL have port branch_en  input  1  relative redirect.
REQ-014 SHALL have port branch_offset  input  ADDR_W  two's-complement byte offset.
REQ-015 SHALL have port pc  output  ADDR_W  current PC (registered).
REQ-016 SHALL have port pc_plus4  output  ADDR_W  pc + 4, combinational.
REQ-017 SHALL have port ras_empty  output  1  RAS count == 0.
REQ-018 SHALL have port ras_full  output  1  RAS count == RAS_DEPTH.
REQ-019 SHALL have port misalign  output  1  one-cycle registered pulse, misaligned target taken.
REQ-020 SHALL have port ras_underflow  output  1  one-cycle registered pulse, ret taken with RAS empty.

Function
REQ-021 SHALL update pc only on rising clock edges; next-PC priority: exc_req > stall > ret > jump_en > branch_en > sequential.
REQ-022 SHALL load EXC_VECTOR on exc_req regardless of stall, and flush RAS count to 0 in the same edge.
REQ-023 SHALL hold pc, RAS and both pulse outputs at 0 while stall=1 and exc_req=0; all other requests are ignored.
REQ-024 SHALL, on ret with RAS non-empty, load the top entry and decrement count; with RAS empty, load pc+4 and pulse ras_underflow.
REQ-025 SHALL, on jump_en (ret=0), load jump_target; if call=1, additionally push pc+4 in the same edge.
REQ-026 SHALL, on push with RAS full, overwrite the oldest entry (circular); count saturates at RAS_DEPTH.
REQ-027 SHALL ignore call when jump_en=0 or when ret/exc_req/stall wins; ret+call in one cycle performs pop only.
REQ-028 SHALL, on branch_en, load pc + branch_offset modulo 2^ADDR_W (wrap-around, no overflow flag).
REQ-029 SHALL otherwise load pc + 4 modulo 2^ADDR_W (0xFFFFFFFC -> 0x00000000 at ADDR_W=32).
REQ-030 SHALL force bits [1:0] of any selected jump/branch/ret target to 0 and pulse misalign one cycle later when they were nonzero.
REQ-031 SHALL deassert misalign and ras_underflow after exactly one cycle unless retriggered.

Reset
REQ-032 SHALL, on reset assertion (asynchronous, mid-operation included), set pc=RESET_VECTOR, RAS count=0, misalign=0, ras_underflow=0; RAS entry contents need not be cleared.
REQ-033 SHALL resume sequential fetch from RESET_VECTOR on the first clock edge after reset deasserts.

Configuration
REQ-034 SHALL, with macro NEXT_PC_RAS_EN defined, implement the return-address stack per REQ-022..027.
REQ-035 SHALL, without NEXT_PC_RAS_EN, omit RAS storage: call ignored, ret treated as no request, ras_empty tied 1, ras_full and ras_underflow tied 0.

Verification
REQ-036 SHALL cover reset then 3 free-running clocks -> pc 0x3000, 0x3004, 0x3008, 0x300C.
REQ-037 SHALL cover pc=0x3010, jump_en=1 call=1 jump_target=0x5000, then ret=1 -> pc 0x5000 then 0x3014, ras_empty 0->1.
REQ-038 SHALL cover 5 calls with RAS_DEPTH=4 then 5 rets -> last 4 return addresses in LIFO order, 5th ret gives pc+4 with ras_underflow pulse.
REQ-039 SHALL cover stall=1 with jump_en=1 for 2 cycles, then exc_req=1 while stall=1 -> pc held, then pc=0x4180 and ras_empty=1.
REQ-040 SHALL cover pc=0x3000, branch_en=1 branch_offset=0xFFFFFFF6 -> pc=0x2FF4 and misalign pulse; reset asserted mid-cycle -> pc=0x3000 immediately.
